// File: rtl/multicycle_control.sv
// Main decoder / sequencer for the 8-bit multicycle processor.
// Walks one micro-step per clock and drives every datapath control input.
//
// state   | meaning
// FETCH   | read instruction at PC, PC <= PC + 1
// DECODE  | read register file, pick immediate format
// EXEC_R  | data-processing ALU op, register operand
// EXEC_I  | data-processing ALU op, immediate operand
// ALU_WB  | write ALU result to Rd
// MEM_ADR | compute memory address
// MEM_RD  | read data memory
// MEM_WB  | write loaded data to Rd
// MEM_WR  | write data memory
// BRANCH  | conditional PC update, optional link
// SHIFT   | shifter op with writeback
// HALT    | parked until reset
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] instr,
  output logic        RegWrite,
  output logic        LRWrite,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        ALUSrcA,
  output logic        FlagUp,
  output logic        PC_Sel,
  output logic [1:0]  AdrSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ALUControl,
  output logic [2:0]  PCWrite,
  output logic [2:0]  ShftDcd,
  output logic [3:0]  state,
  output logic        instr_done
);

  localparam logic [19:0] HALT_WORD = 20'hFFFFF;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ALU_WB  = 4'd4,
    S_MEM_ADR = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WB  = 4'd7,
    S_MEM_WR  = 4'd8,
    S_BRANCH  = 4'd9,
    S_SHIFT   = 4'd10,
    S_HALT    = 4'd15
  } state_t;

  state_t     state_q;
  logic [1:0] op;
  logic [2:0] cond;
  logic       bit_i_l;

  assign op      = instr[19:18];
  assign cond    = instr[17:15];
  assign bit_i_l = instr[15];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:   state_q <= S_DECODE;
        S_DECODE: begin
          if (instr == HALT_WORD) state_q <= S_HALT;
          else begin
            case (op)
              OP_DP:    state_q <= bit_i_l ? S_EXEC_I : S_EXEC_R;
              OP_MEM:   state_q <= S_MEM_ADR;
              OP_BR:    state_q <= S_BRANCH;
              OP_SHIFT: state_q <= S_SHIFT;
              default:  state_q <= S_FETCH;
            endcase
          end
        end
        S_EXEC_R:  state_q <= S_ALU_WB;
        S_EXEC_I:  state_q <= S_ALU_WB;
        S_MEM_ADR: state_q <= bit_i_l ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:  state_q <= S_MEM_WB;
        S_HALT:    state_q <= S_HALT;
        // writeback states and any unused code fall back to a fresh fetch
        default:   state_q <= S_FETCH;
      endcase
    end
  end

  // Moore outputs, gated off entirely while reset is held.
  always_comb begin
    RegWrite   = 1'b0;
    LRWrite    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ALUSrcA    = 1'b0;
    FlagUp     = 1'b0;
    PC_Sel     = 1'b0;
    AdrSrc     = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 3'b000;
    PCWrite    = 3'b000;
    ShftDcd    = 3'b000;
    instr_done = 1'b0;
    state      = rst ? state_q : 4'd0;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          IRWrite = 1'b1;
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          PC_Sel  = 1'b1;
          PCWrite = 3'b001;
        end
        S_DECODE: begin
          ImmSrc = (op == OP_BR) ? 2'b10 : (op == OP_MEM) ? 2'b01 : 2'b00;
          RegSrc = {(op == OP_MEM) && !bit_i_l, op == OP_BR};
        end
        S_EXEC_R, S_EXEC_I: begin
          ALUSrcB    = (state_q == S_EXEC_I) ? 2'b01 : 2'b00;
          ALUControl = instr[14:12];
          FlagUp     = instr[11];
        end
        S_ALU_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_ADR: begin
          ALUSrcB = 2'b01;
          ImmSrc  = 2'b01;
        end
        S_MEM_RD: AdrSrc = 2'b01;
        S_MEM_WB: begin
          ResultSrc  = 2'b01;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          AdrSrc     = 2'b01;
          MemWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b01;
          ImmSrc     = 2'b10;
          ResultSrc  = 2'b10;
          PCWrite    = (cond == 3'b000) ? 3'b001 : cond;
          LRWrite    = instr[14];
          instr_done = 1'b1;
        end
        S_SHIFT: begin
          ShftDcd    = instr[14:12];
          ResultSrc  = 2'b10;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction expected output
// sequences are queued by the stimulus and consumed by a negedge monitor.
`timescale 1ns/1ps
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] instr = 20'h00000;
  logic        RegWrite, LRWrite, MemWrite, IRWrite, ALUSrcA, FlagUp, PC_Sel;
  logic [1:0]  AdrSrc, ALUSrcB, ImmSrc, RegSrc, ResultSrc;
  logic [2:0]  ALUControl, PCWrite, ShftDcd;
  logic [3:0]  state;
  logic        instr_done;

  typedef struct packed {
    logic [3:0] st;
    logic       rw, lrw, mw, irw, asa, fu, pcs;
    logic [1:0] adr, asb, imm, rsrc, res;
    logic [2:0] alu, pcw, sh;
    logic       done;
  } vec_t;

  vec_t exp_q[$];
  vec_t gen_q[$];
  vec_t act;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .instr(instr),
    .RegWrite(RegWrite), .LRWrite(LRWrite), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .FlagUp(FlagUp), .PC_Sel(PC_Sel),
    .AdrSrc(AdrSrc), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .PCWrite(PCWrite),
    .ShftDcd(ShftDcd), .state(state), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  assign act = {state, RegWrite, LRWrite, MemWrite, IRWrite, ALUSrcA, FlagUp, PC_Sel,
                AdrSrc, ALUSrcB, ImmSrc, RegSrc, ResultSrc, ALUControl, PCWrite,
                ShftDcd, instr_done};

  // Reference: the full cycle-by-cycle output sequence of one instruction.
  task automatic build(input logic [19:0] ins, input int halt_cycles);
    vec_t v;
    logic [1:0] op;
    op = ins[19:18];
    gen_q.delete();
    v = '0; v.st = 4'd0; v.irw = 1; v.asa = 1; v.asb = 2'b10; v.pcs = 1; v.pcw = 3'b001;
    gen_q.push_back(v);
    v = '0; v.st = 4'd1;
    v.imm  = (op == 2'b10) ? 2'b10 : (op == 2'b01) ? 2'b01 : 2'b00;
    v.rsrc = {(op == 2'b01) && (ins[15] == 1'b0), op == 2'b10};
    gen_q.push_back(v);
    if (ins == 20'hFFFFF) begin
      for (int k = 0; k < halt_cycles; k++) begin
        v = '0; v.st = 4'd15; gen_q.push_back(v);
      end
    end else begin
      case (op)
        2'b00: begin
          v = '0; v.st = ins[15] ? 4'd3 : 4'd2; v.asb = ins[15] ? 2'b01 : 2'b00;
          v.alu = ins[14:12]; v.fu = ins[11]; gen_q.push_back(v);
          v = '0; v.st = 4'd4; v.rw = 1; v.done = 1; gen_q.push_back(v);
        end
        2'b01: begin
          v = '0; v.st = 4'd5; v.asb = 2'b01; v.imm = 2'b01; gen_q.push_back(v);
          if (ins[15]) begin
            v = '0; v.st = 4'd6; v.adr = 2'b01; gen_q.push_back(v);
            v = '0; v.st = 4'd7; v.res = 2'b01; v.rw = 1; v.done = 1; gen_q.push_back(v);
          end else begin
            v = '0; v.st = 4'd8; v.adr = 2'b01; v.mw = 1; v.done = 1; gen_q.push_back(v);
          end
        end
        2'b10: begin
          v = '0; v.st = 4'd9; v.asa = 1; v.asb = 2'b01; v.imm = 2'b10; v.res = 2'b10;
          v.pcw = (ins[17:15] == 3'b000) ? 3'b001 : ins[17:15];
          v.lrw = ins[14]; v.done = 1; gen_q.push_back(v);
        end
        default: begin
          v = '0; v.st = 4'd10; v.sh = ins[14:12]; v.res = 2'b10; v.rw = 1; v.done = 1;
          gen_q.push_back(v);
        end
      endcase
    end
  endtask

  // Called at the start of a FETCH cycle (#1 after the edge). cut>0 truncates
  // the run so reset can be asserted in the cycle that follows.
  task automatic run_instr(input logic [19:0] ins, input int cut);
    int n;
    build(ins, 10);
    n = gen_q.size();
    if (cut > 0 && cut < n) n = cut;
    for (int k = 0; k < n; k++) exp_q.push_back(gen_q[k]);
    @(posedge clk); #1 instr = ins;
    repeat (n - 1) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input int cycles);
    rst = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      checks++;
      if (act !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d actual=%h required=%h", cyc, act, 31'h0);
      end
    end else if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL seq_outputs cycle=%0d instr=%h actual=%h (state %0d) required=%h (state %0d)",
                 cyc, instr, act, act.st, e, e.st);
      end
    end else begin
      checks++;
      failures++;
      $display("FAIL no_expectation cycle=%0d actual=%h", cyc, act);
    end
  end

  initial begin
    logic [19:0] r;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    build(20'h00000, 0);
    exp_q.push_back(gen_q[0]);
    rst = 1'b1;
    // first fetch expectation already queued; issue the DP instruction's tail
    build(20'h03800, 0);
    for (int k = 1; k < gen_q.size(); k++) exp_q.push_back(gen_q[k]);
    @(posedge clk); #1 instr = 20'h03800;
    repeat (gen_q.size() - 1) @(posedge clk);
    #1;
    run_instr(20'h0B800, 0);
    run_instr(20'h48000, 0);
    run_instr(20'h40000, 0);
    run_instr(20'h94000, 0);
    run_instr(20'h80000, 0);
    run_instr(20'hC5000, 0);
    run_instr(20'hA8000, 0);
    for (int i = 0; i < 80; i++) begin
      r = 20'($urandom());
      if (r == 20'hFFFFF) r = 20'h7FFFF;
      run_instr(r, 0);
    end
    run_instr(20'h40000, 3);
    reset_pulse(1);
    run_instr(20'hFFFFF, 0);
    reset_pulse(1);
    run_instr(20'h48000, 0);
    for (int i = 0; i < 20; i++) begin
      r = 20'($urandom());
      if (r == 20'hFFFFF) r = 20'h3FFFF;
      run_instr(r, 0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
